bf16_to_int: RTL and testbench

//  Converts a BF16 operand (1 sign, 8 exp bias 127, 7 mantissa) into a signed OUT_W-bit
//  two's-complement integer. It is the inverse of the integer-to-BF16 packing used by the

---
 rtl/bf16_to_int_if.sv | 21 ++
 rtl/bf16_to_int.sv | 102 ++++++++++
 tb/tb_bf16_to_int.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/bf16_to_int_if.sv
// rtl/bf16_to_int_if.sv - start/busy/done handshake bundle for the BF16-to-integer converter
interface bf16_to_int_if #(
    parameter int OUT_W = 16
) ();
    logic             start;
    logic [15:0]      a;
    logic             busy;
    logic [OUT_W-1:0] result;
    logic             error;
    logic             done;

    modport master (
        output start, a,
        input  busy, result, error, done
    );

    modport slave (
        input  start, a,
        output busy, result, error, done
    );
endinterface

// File: rtl/bf16_to_int.sv
// rtl/bf16_to_int.sv - iterative BF16 to signed OUT_W-bit integer converter (truncating, saturating)
module bf16_to_int #(
    parameter int OUT_W = 16
) (
    input  logic          clk,
    input  logic          rst,
    bf16_to_int_if.slave  bus
);
    localparam int WW    = OUT_W + 8;
    localparam int CNT_W = 8;
    localparam logic [OUT_W-1:0] MAX_POS = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] MIN_NEG = {1'b1, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, UNPACK, SHIFT, NEGATE} state_t;

    state_t           state;
    logic [15:0]      a_q;
    logic [WW-1:0]    work;
    logic [CNT_W-1:0] cnt;
    logic             dir_left;

    logic       s;
    logic [7:0] ex;
    logic [6:0] man;
    int         e_val;

    assign s     = a_q[15];
    assign ex    = a_q[14:7];
    assign man   = a_q[6:0];
    assign e_val = int'(ex) - 127;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            a_q        <= '0;
            work       <= '0;
            cnt        <= '0;
            dir_left   <= 1'b0;
            bus.busy   <= 1'b0;
            bus.result <= '0;
            bus.error  <= 1'b0;
            bus.done   <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_q      <= bus.a;
                        bus.busy <= 1'b1;
                        state    <= UNPACK;
                    end
                end
                UNPACK: begin
                    if (ex == 8'hFF) begin
                        bus.result <= (man != 7'd0) ? '0 : (s ? MIN_NEG : MAX_POS);
                        bus.error  <= 1'b1;
                        bus.done   <= 1'b1;
                        bus.busy   <= 1'b0;
                        state      <= IDLE;
                    end else if (ex == 8'h00 || e_val < 0) begin
                        bus.result <= '0;
                        bus.error  <= 1'b0;
                        bus.done   <= 1'b1;
                        bus.busy   <= 1'b0;
                        state      <= IDLE;
                    end else if (e_val >= OUT_W - 1) begin
                        // Exactly -2^(OUT_W-1) is representable; everything else beyond range clips.
                        if (s && e_val == OUT_W - 1 && man == 7'd0) begin
                            bus.result <= MIN_NEG;
                            bus.error  <= 1'b0;
                        end else begin
                            bus.result <= s ? MIN_NEG : MAX_POS;
                            bus.error  <= 1'b1;
                        end
                        bus.done <= 1'b1;
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        work     <= {{OUT_W{1'b0}}, 1'b1, man};
                        dir_left <= (e_val >= 7);
                        cnt      <= (e_val >= 7) ? CNT_W'(e_val - 7) : CNT_W'(7 - e_val);
                        state    <= (e_val == 7) ? NEGATE : SHIFT;
                    end
                end
                SHIFT: begin
                    work <= dir_left ? (work << 1) : (work >> 1);
                    cnt  <= cnt - 1'b1;
                    if (cnt == CNT_W'(1))
                        state <= NEGATE;
                end
                NEGATE: begin
                    bus.result <= s ? -work[OUT_W-1:0] : work[OUT_W-1:0];
                    bus.error  <= 1'b0;
                    bus.done   <= 1'b1;
                    bus.busy   <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bf16_to_int.sv
// tb/tb_bf16_to_int.sv - scoreboard bench for bf16_to_int with directed hand-computed vectors
module tb_bf16_to_int;
    logic clk;
    logic rst;
    int   cyc;
    int   nvec;
    int   nfail;

    bf16_to_int_if #(.OUT_W(16)) bus ();

    bf16_to_int #(.OUT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [15:0] res;
        logic        err;
        int          lat;
        int          stamp;
    } exp_t;

    exp_t sb[$];

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] r;
        logic        e;
        logic [7:0]  lat;
    } vec_t;

    localparam vec_t VECS [16] = '{
        '{16'h4120, 16'h000A, 1'b0, 8'd7},
        '{16'hC2F6, 16'hFF85, 1'b0, 8'd4},
        '{16'h46FF, 16'h7F80, 1'b0, 8'd10},
        '{16'h3F00, 16'h0000, 1'b0, 8'd2},
        '{16'h0000, 16'h0000, 1'b0, 8'd2},
        '{16'h0040, 16'h0000, 1'b0, 8'd2},
        '{16'h7F80, 16'h7FFF, 1'b1, 8'd2},
        '{16'hFF80, 16'h8000, 1'b1, 8'd2},
        '{16'h7FC0, 16'h0000, 1'b1, 8'd2},
        '{16'hC700, 16'h8000, 1'b0, 8'd2},
        '{16'h4700, 16'h7FFF, 1'b1, 8'd2},
        '{16'h3F80, 16'h0001, 1'b0, 8'd10},
        '{16'h4300, 16'h0080, 1'b0, 8'd3},
        '{16'hBFC0, 16'hFFFF, 1'b0, 8'd10},
        '{16'hC6FF, 16'h8080, 1'b0, 8'd10},
        '{16'hC680, 16'hC000, 1'b0, 8'd10}
    };

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && bus.done) begin
            if (sb.size() == 0) begin
                nfail++;
                $display("FAIL unexpected_done: got done=1 result=%h, required no completion", bus.result);
            end else begin
                exp_t x;
                x = sb.pop_front();
                if (bus.result !== x.res) begin
                    nfail++;
                    $display("FAIL result: got %h, required %h", bus.result, x.res);
                end
                if (bus.error !== x.err) begin
                    nfail++;
                    $display("FAIL error: got %b, required %b (result %h)", bus.error, x.err, x.res);
                end
                if (cyc - x.stamp != x.lat) begin
                    nfail++;
                    $display("FAIL latency: got %0d, required %0d (result %h)", cyc - x.stamp, x.lat, x.res);
                end
                if (bus.busy !== 1'b0) begin
                    nfail++;
                    $display("FAIL busy_at_done: got %b, required 0", bus.busy);
                end
            end
        end
    end

    task automatic issue(input logic [15:0] av, input logic [15:0] er, input logic ee,
                         input int lat, input bit push);
        bus.a     = av;
        bus.start = 1'b1;
        if (push) sb.push_back('{er, ee, lat, cyc});
        nvec++;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (bus.done !== 1'b1 && n < 40) begin
            if (bus.busy !== 1'b1) begin
                nfail++;
                $display("FAIL busy_while_converting: got %b, required 1", bus.busy);
            end
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            nfail++;
            $display("FAIL done_timeout: got no done in %0d cycles, required done", n);
        end
    endtask

    initial begin
        cyc       = 0;
        nvec      = 0;
        nfail     = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        if ({bus.busy, bus.done, bus.error, bus.result} !== 19'd0) begin
            nfail++;
            $display("FAIL reset_state: got busy=%b done=%b error=%b result=%h, required all 0",
                     bus.busy, bus.done, bus.error, bus.result);
        end
        @(negedge clk);

        // Back-to-back: each new start is driven in the cycle done is seen.
        foreach (VECS[i]) begin
            issue(VECS[i].a, VECS[i].r, VECS[i].e, int'(VECS[i].lat), 1'b1);
            wait_done();
        end
        @(negedge clk);

        // A start while busy must be dropped.
        issue(16'h4120, 16'h000A, 1'b0, 7, 1'b1);
        @(negedge clk);
        bus.a     = 16'h4000;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = 16'h0000;
        wait_done();
        repeat (12) @(negedge clk);

        // Abort mid-shift: no done, outputs clear at once.
        issue(16'h46FF, 16'h0000, 1'b0, 0, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        if ({bus.busy, bus.done, bus.error, bus.result} !== 19'd0) begin
            nfail++;
            $display("FAIL abort_reset: got busy=%b done=%b error=%b result=%h, required all 0",
                     bus.busy, bus.done, bus.error, bus.result);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        issue(16'h4120, 16'h000A, 1'b0, 7, 1'b1);
        wait_done();
        repeat (12) @(negedge clk);

        if (sb.size() != 0) begin
            nfail++;
            $display("FAIL missing_done: got %0d outstanding, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
